regbank_wr_arbiter: RTL

- Shares the register bank's single write port among NREQ writeback requesters: ALU, load unit and multi-cycle mul/div.
- Uses round-robin arbitration with valid/ready handshakes.
- Registers the winning write onto the bank's wrReg/rd/rdIn inputs.
- Keeps a 32-bit pending-write scoreboard so decode can stall on RAW hazards against in-flight writes.

---
 rtl/regbank_pkg.sv | 11 +
 rtl/regbank_wr_arbiter_rr.sv | 56 +++++
 rtl/regbank_wr_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared register-bank constants and address/data types.
package regbank_pkg;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned REG_DW   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/regbank_wr_arbiter_rr.sv
// Round-robin arbiter: NREQ valid bits in, one-hot grant out.
// Build option RBARB_FIXED_PRIO_EN: fixed priority (requester 0 highest), no pointer.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant
);

`ifdef RBARB_FIXED_PRIO_EN
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && i_valid[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`else
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_found;
  int unsigned   w_idx;

  // Scan from the pointer, wrapping; the winner's successor becomes the next pointer.
  always_comb begin
    o_grant   = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && i_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
        w_ptr_nxt      = PW'((w_idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ptr <= '0;
    else if (i_advance) r_ptr <= w_ptr_nxt;
  end
`endif

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Register-bank write-port arbiter with registered write and pending-write scoreboard.
// Build option RBARB_FIXED_PRIO_EN selects fixed priority inside rr_arbiter.
module regbank_wr_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_rd,
  input  logic [AW-1:0]        q_rs,
  input  logic [AW-1:0]        q_rt,
  output logic                 rs_busy,
  output logic                 rt_busy,
  output logic [NUM_REGS-1:0]  pending
);

  logic [NREQ-1:0]     w_grant;
  logic                w_acc;
  logic [AW-1:0]       w_sel_rd;
  logic [DW-1:0]       w_sel_data;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [DW-1:0]       r_wr_data;
  logic [NUM_REGS-1:0] r_pending;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (req_valid),
    .i_advance (w_acc),
    .o_grant   (w_grant)
  );

  assign w_acc     = |w_grant;
  assign req_ready = rst ? '0 : w_grant;

  // Grant is one-hot, so an OR-mux selects the winner's payload.
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_rd   = w_sel_rd   | req_rd[i*AW +: AW];
        w_sel_data = w_sel_data | req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_acc) begin
      r_wr_en   <= (w_sel_rd != AW'(ZERO_REG));
      r_wr_addr <= w_sel_rd;
      r_wr_data <= w_sel_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // A reservation beats a same-cycle writeback: the newer producer owns the register.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rsv_valid && rsv_rd != AW'(ZERO_REG)) w_set = NUM_REGS'(1) << rsv_rd;
    if (w_acc)                                w_clr = NUM_REGS'(1) << w_sel_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= ((r_pending & ~w_clr) | w_set) & ~NUM_REGS'(1);
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign pending = r_pending;
  assign rs_busy = r_pending[q_rs];
  assign rt_busy = r_pending[q_rt];

endmodule
